// File: rtl/sysid_info_regs.sv
// sysid_info_regs
//   Avalon-MM slave exposing system identity, build timestamp, a 64-bit
//   uptime counter with coherent LO/HI snapshot, a control register and
//   byte-writable scratch words. Reads have a fixed, parameterised latency
//   and are qualified by readdatavalid. There is no waitrequest: every
//   access is accepted in the cycle it is presented.
//
// Ports
//   clock          in   sole clock, rising edge
//   reset_n        in   synchronous active-low reset
//   address[3:0]   in   word address
//   read           in   read strobe
//   write          in   write strobe (wins over a simultaneous read)
//   byteenable[3:0]in   write byte lanes
//   writedata[31:0]in   write data
//   readdata[31:0] out  read data, 0 whenever readdatavalid is low
//   readdatavalid  out  one-cycle read response qualifier
//
// Register map (word addresses)
//   0 ID        1 TS        2 UPTIME_LO (also latches HI_SNAP)
//   3 UPTIME_HI 4 CTRL      5 INFO      8.. SCRATCH
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'd7,
  parameter logic [31:0] TIMESTAMP    = 32'd1383705343,
  parameter int          N_SCRATCH    = 4,
  parameter int          READ_LATENCY = 1,
  // Value the uptime counter takes while reset is applied. Leave at 0 in
  // real systems; a non-zero value lets simulation reach the 32-bit
  // carry without running billions of cycles.
  parameter logic [63:0] UPTIME_INIT  = 64'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int DATA_W = 32;
  localparam int STAGES = READ_LATENCY;

  localparam logic [3:0]        NSCR      = 4'(N_SCRATCH);
  localparam logic [DATA_W-1:0] INFO_WORD = {16'h0000, 8'h02, 4'(READ_LATENCY), NSCR};

  if (N_SCRATCH < 0 || N_SCRATCH > 8) begin : g_bad_n_scratch
    $error("sysid_info_regs: N_SCRATCH must be in 0..8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
    $error("sysid_info_regs: READ_LATENCY must be in 1..4");
  end

  logic              rd_acc;
  logic              wr_acc;
  logic              ctrl_wr;
  logic              clear_wr;
  logic              scr_hit;
  logic              freeze;
  logic [63:0]       uptime;
  logic [31:0]       hi_snap;
  logic [DATA_W-1:0] scratch [8];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_p [STAGES];
  logic              vld_p     [STAGES];

  // A simultaneous write drops the read; nothing is accepted during reset.
  assign rd_acc   = read & ~write & reset_n;
  assign wr_acc   = write & reset_n;
  assign ctrl_wr  = wr_acc && (address == 4'd4) && byteenable[0];
  assign clear_wr = ctrl_wr && writedata[1];
  assign scr_hit  = address[3] && ({1'b0, address[2:0]} < NSCR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      freeze <= writedata[0];
    end
  end

  // CLEAR beats the increment; the increment uses the pre-edge FREEZE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime <= UPTIME_INIT;
    end else if (clear_wr) begin
      uptime <= '0;
    end else if (!freeze) begin
      uptime <= uptime + 64'd1;
    end
  end

  // HI_SNAP takes the same pre-increment value the LO read returns.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi_snap <= '0;
    end else if (rd_acc && (address == 4'd2)) begin
      hi_snap <= uptime[63:32];
    end
  end

  // Words at or above N_SCRATCH are never written and stay at 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) scratch[i] <= '0;
    end else if (wr_acc && scr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch[address[2:0]][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      4'd0:    rd_word = SYSTEM_ID;
      4'd1:    rd_word = TIMESTAMP;
      4'd2:    rd_word = uptime[31:0];
      4'd3:    rd_word = hi_snap;
      4'd4:    rd_word = {30'd0, 1'b0, freeze};
      4'd5:    rd_word = INFO_WORD;
      default: if (scr_hit) rd_word = scratch[address[2:0]];
    endcase
  end

  // ---- stage p0: sample register state in the acceptance cycle ----
  // ---- stages p1..: plain shift, data unreset, valid reset ----
  always_ff @(posedge clock) begin
    if (rd_acc) rd_data_p[0] <= rd_word;
    for (int i = 1; i < STAGES; i++) rd_data_p[i] <= rd_data_p[i-1];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // ---- output: data forced to 0 whenever no response is presented ----
  assign readdatavalid = vld_p[STAGES-1];
  assign readdata      = vld_p[STAGES-1] ? rd_data_p[STAGES-1] : '0;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Testbench for sysid_info_regs.
//   Instance A: READ_LATENCY=2, counter reset value 0xFFFFFFFE (reaches the
//               32-bit carry quickly). Instance B: READ_LATENCY=3 defaults,
//               used for the mid-read reset sequence.
//   Expected read words are queued with their due cycle when a read is
//   driven and popped when readdatavalid appears.
module tb_sysid_info_regs;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          id;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic        sel, rd, wr;
  logic [3:0]  address, byteenable;
  logic [31:0] writedata;
  logic [31:0] rdata_a, rdata_b;
  logic        rdv_a, rdv_b;
  logic        rd_a, wr_a, rd_b, wr_b;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  assign rd_a = rd & ~sel;
  assign wr_a = wr & ~sel;
  assign rd_b = rd & sel;
  assign wr_b = wr & sel;

  sysid_info_regs #(
    .READ_LATENCY(2),
    .UPTIME_INIT (64'h0000_0000_FFFF_FFFE)
  ) dut_a (
    .clock        (clock),
    .reset_n      (rst_n_a),
    .address      (address),
    .read         (rd_a),
    .write        (wr_a),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .readdata     (rdata_a),
    .readdatavalid(rdv_a)
  );

  sysid_info_regs #(
    .READ_LATENCY(3)
  ) dut_b (
    .clock        (clock),
    .reset_n      (rst_n_b),
    .address      (address),
    .read         (rd_b),
    .write        (wr_b),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .readdata     (rdata_b),
    .readdatavalid(rdv_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Response checker, sampled on the falling edge.
  always @(negedge clock) begin
    if (rdv_a) begin
      n_vec++;
      assert (qa.size() != 0) else begin
        n_err++; $error("FAIL a_unexpected_valid observed=%0b expected=0 cyc=%0d", rdv_a, cyc);
      end
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        n_vec++;
        assert (rdata_a === ea.data) else begin
          n_err++; $error("FAIL a_data id=%0d observed=%h expected=%h", ea.id, rdata_a, ea.data);
        end
        n_vec++;
        assert (cyc === ea.due) else begin
          n_err++; $error("FAIL a_latency id=%0d observed=%0d expected=%0d", ea.id, cyc, ea.due);
        end
      end
    end else begin
      n_vec++;
      assert (rdata_a === 32'h0) else begin
        n_err++; $error("FAIL a_idle_data observed=%h expected=00000000", rdata_a);
      end
      if (qa.size() != 0) begin
        n_vec++;
        assert (cyc <= qa[0].due) else begin
          n_err++; $error("FAIL a_missing id=%0d observed_cyc=%0d expected_by=%0d", qa[0].id, cyc, qa[0].due);
          void'(qa.pop_front());
        end
      end
    end

    if (rdv_b) begin
      n_vec++;
      assert (qb.size() != 0) else begin
        n_err++; $error("FAIL b_unexpected_valid observed=%0b expected=0 cyc=%0d", rdv_b, cyc);
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        n_vec++;
        assert (rdata_b === eb.data) else begin
          n_err++; $error("FAIL b_data id=%0d observed=%h expected=%h", eb.id, rdata_b, eb.data);
        end
        n_vec++;
        assert (cyc === eb.due) else begin
          n_err++; $error("FAIL b_latency id=%0d observed=%0d expected=%0d", eb.id, cyc, eb.due);
        end
      end
    end else begin
      n_vec++;
      assert (rdata_b === 32'h0) else begin
        n_err++; $error("FAIL b_idle_data observed=%h expected=00000000", rdata_b);
      end
      if (qb.size() != 0) begin
        n_vec++;
        assert (cyc <= qb[0].due) else begin
          n_err++; $error("FAIL b_missing id=%0d observed_cyc=%0d expected_by=%0d", qb[0].id, cyc, qb[0].due);
          void'(qb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one read, queue its expected word, due READ_LATENCY cycles later.
  task automatic rd_op(input bit s, input logic [3:0] a, input logic [31:0] e, input int id);
    exp_t ent;
    sel        = s;
    address    = a;
    byteenable = 4'h0;
    rd         = 1'b1;
    ent.data   = e;
    ent.id     = id;
    ent.due    = cyc + (s ? 3 : 2);
    if (s) qb.push_back(ent);
    else   qa.push_back(ent);
    tick();
    rd = 1'b0;
  endtask

  task automatic wr_op(input bit s, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    sel        = s;
    address    = a;
    byteenable = be;
    writedata  = d;
    wr         = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    address = 4'h0; byteenable = 4'h0; writedata = 32'h0;
    repeat (3) tick();

    // Release both; A is frozen on its first active edge (counter -> FFFFFFFF).
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    wr_op(1'b0, 4'd4, 4'hF, 32'h1);

    // Identity and latency, back-to-back.
    rd_op(1'b0, 4'd0, 32'h0000_0007, 1);
    rd_op(1'b0, 4'd1, 32'h5279_AAFF, 2);
    rd_op(1'b0, 4'd5, 32'h0000_0224, 3);

    // Snapshot just below the 32-bit carry.
    rd_op(1'b0, 4'd2, 32'hFFFF_FFFF, 4);
    rd_op(1'b0, 4'd3, 32'h0000_0000, 5);

    // Unfreeze for one cycle, refreeze: counter = 1_00000000.
    wr_op(1'b0, 4'd4, 4'hF, 32'h0);
    wr_op(1'b0, 4'd4, 4'hF, 32'h1);
    rd_op(1'b0, 4'd2, 32'h0000_0000, 6);
    rd_op(1'b0, 4'd3, 32'h0000_0001, 7);

    // Scratch byte lanes, unpopulated scratch word, read-after-write.
    wr_op(1'b0, 4'd9, 4'hF, 32'hDEAD_BEEF);
    wr_op(1'b0, 4'd9, 4'b0010, 32'h0000_1200);
    rd_op(1'b0, 4'd9, 32'hDEAD_12EF, 8);
    rd_op(1'b0, 4'd12, 32'h0000_0000, 9);
    wr_op(1'b0, 4'd8, 4'hF, 32'hA5A5_A5A5);
    rd_op(1'b0, 4'd8, 32'hA5A5_A5A5, 10);

    // Read-only word and CTRL without byte lane 0.
    wr_op(1'b0, 4'd0, 4'hF, 32'h1234_5678);
    rd_op(1'b0, 4'd0, 32'h0000_0007, 11);
    wr_op(1'b0, 4'd4, 4'b1110, 32'h0000_0000);
    rd_op(1'b0, 4'd4, 32'h0000_0001, 12);

    // Read and write together: write lands, read produces no response.
    sel = 1'b0; address = 4'd8; byteenable = 4'hF; writedata = 32'h1122_3344;
    rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    rd_op(1'b0, 4'd8, 32'h1122_3344, 13);

    // CLEAR against a running counter.
    wr_op(1'b0, 4'd4, 4'hF, 32'h0);
    repeat (3) tick();
    wr_op(1'b0, 4'd4, 4'hF, 32'h2);
    rd_op(1'b0, 4'd2, 32'h0000_0000, 14);
    rd_op(1'b0, 4'd2, 32'h0000_0001, 15);
    rd_op(1'b0, 4'd4, 32'h0000_0000, 16);

    // Instance B: populate scratch, then reset with a read in flight.
    wr_op(1'b1, 4'd8, 4'hF, 32'hCAFE_F00D);
    rd_op(1'b1, 4'd8, 32'hCAFE_F00D, 20);
    repeat (4) tick();
    sel = 1'b1; address = 4'd0; rd = 1'b1;
    tick();
    rd = 1'b0;
    rst_n_b = 1'b0;
    // Accesses presented during reset are ignored.
    address = 4'd9; byteenable = 4'hF; writedata = 32'hFFFF_FFFF;
    rd = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
    tick();
    rd = 1'b0;
    rst_n_b = 1'b1;
    tick();
    rd_op(1'b1, 4'd2, 32'h0000_0001, 21);
    rd_op(1'b1, 4'd3, 32'h0000_0000, 22);
    rd_op(1'b1, 4'd8, 32'h0000_0000, 23);
    rd_op(1'b1, 4'd9, 32'h0000_0000, 24);

    repeat (10) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
